aurora_see_injector: RTL and testbench
======================================

Name: aurora_see_injector

Overview:
- Parametrised, synthesizable line-impairment model for the Aurora 64b/66b RX test path. It also runs in simulation.
- Accepts scrambled BLOCK_W-bit blocks over a valid/ready handshake. Applies pseudo-random bit flips, drops and duplications (up to 3 of each per block), with runtime thresholds driven by an internal LFSR.
- Serialises the result MSB-first at one bit per clock into the lane deserialiser input.
- Keeps saturating event counters, so the receiver slip/recovery statistics can be checked against ground truth.

Parameters:
- BLOCK_W, 66, block width in bits including 2-bit sync header.
- BUF_W, 3*BLOCK_W, serial bit buffer depth (must be at least 2*BLOCK_W+3).
- LFSR_SEED, 32'hACE1_2468, nonzero LFSR reset value.
- CNT_W, 16, width of the event counters.

Ports:
- clk_serdes_i  in  1  bit clock, one serial bit per cycle.
- rst_n_i  in  1  asynchronous active-low reset.
- blk_data_i  in  BLOCK_W  input block.
- blk_valid_i  in  1  block valid.
- blk_ready_o  out  1  block accepted when valid&ready.
- inj_en_i  in  1  enable impairment; 0 gives pass-through.
- flip_thresh_i  in  20  flip probability, out of 2^20.
- drop_thresh_i  in  20  drop probability, out of 2^20.
- add_thresh_i  in  20  duplication probability, out of 2^20.
- max_err_i  in  2  max events per type per block (0..3).
- ser_o  out  1  serial data.
- ser_valid_o  out  1  ser_o carries a buffered bit.
- underrun_o  out  1  sticky: buffer empty after first accept.
- blk_cnt_o  out  32  blocks accepted (wraps).
- flip_cnt_o  out  CNT_W  flips applied, saturating.
- drop_cnt_o  out  CNT_W  drops applied, saturating.
- add_cnt_o  out  CNT_W  duplications applied, saturating.

Behaviour:
- Reset values: all outputs 0. blk_ready_o=0. Buffer length len=0. LFSR=LFSR_SEED. FSM=IDLE.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1. Advances every cycle the FSM is not IDLE.
- Event-count draw for each type T, from r=lfsr[19:0]:
  - n_T=0 if r>=thresh_T or !inj_en_i.
  - Otherwise n_T=1, 2 if r<thresh_T>>4, 3 if r<thresh_T>>8.
  - n_T is then clamped to max_err_i.
- Position draw: pos=(lfsr[15:0]*cur_len)>>16, giving range 0..cur_len-1, where cur_len is the current working length.
- FSM states:
  - IDLE: blk_ready_o=(len<=BLOCK_W). On accept: latch block into work register (width BLOCK_W+3), cur_len=BLOCK_W, go to DRAW.
  - DRAW (1 cycle): compute n_flip, n_drop, n_add. Go to MUTATE.
  - MUTATE: one event per cycle, in order flips, drops, adds.
    - Flip: invert bit pos.
    - Drop: remove bit pos; higher bits shift down; cur_len-1.
    - Add: higher bits and bit pos shift up; bit pos duplicated; cur_len+1.
    - Each event increments its counter, saturating at all-ones.
    - When all events are done, go to APPEND.
  - APPEND (1 cycle): work[cur_len-1:0] appended below buffered bits; len+=cur_len; blk_cnt_o+1; go to IDLE.
- Latency from accept to append: 2+n_flip+n_drop+n_add cycles (max 11).
- Output, every cycle:
  - If len>0: ser_o=buf[len-1], ser_valid_o=1, len-1.
  - Else ser_valid_o=0, ser_o=0.
  - Append and shift in the same cycle: len_next=len-1+cur_len, and the appended bits sit below the remaining ones.
- underrun_o sets when len==0 after at least one accept; cleared only by reset.
- Continuous valid input produces a gap-free stream: accept at len<=BLOCK_W leaves at least 55 bits of margin over worst-case latency.
- blk_data_i is sampled only at accept. The source may hold or change it while ready=0.
- Reset mid-operation: buffer and in-flight block discarded. LFSR reloaded, so the impairment sequence is reproducible from reset.
- Threshold and enable changes take effect at the next DRAW.

Test Plan:
- Pass-through: thresholds 0 (or inj_en_i=0), blocks {2'b01,cnt,cnt}, cnt=0..99, valid held high.
  - Serial stream bit-exact to input, MSB-first.
  - ser_valid_o continuous after first bit; all event counters 0; blk_cnt_o=100; underrun_o=0.
- Flip always: flip_thresh_i=20'hFFFFF, max_err_i=1, 50 blocks.
  - Each 66-bit output block differs from input in exactly 1 bit; flip_cnt_o=50.
- Drop always: drop_thresh_i=20'hFFFFF, max_err_i=1, 40 blocks.
  - Exactly 40*65=2600 valid bits; each block equals input with one bit removed; drop_cnt_o=40.
- Duplicate: add_thresh_i=20'hFFFFF, max_err_i=1, 40 blocks.
  - 67 bits per block; inserted bit equals its original neighbour; add_cnt_o=40.
  - Repeat with max_err_i=0: exactly 66 bits per block, add_cnt_o=0.
- Starvation: 3 blocks, then blk_valid_i low for 200 cycles.
  - ser_valid_o falls after 198 bits; underrun_o=1 and stays 1 after traffic resumes.
- Reset and saturation:
  - Reset mid-MUTATE: outputs 0 within the reset window. Rerunning the same stimulus yields an identical impaired stream.
  - With CNT_W=4 and flip always: flip_cnt_o stops at 15.

Source files
------------

// File: rtl/aurora_see_injector_if.sv
// Block handshake bundle for aurora_see_injector.
// The block source drives data and valid; the injector returns ready.
//   blk_data_i  : BLOCK_W-bit scrambled block, sync header in the top two bits
//   blk_valid_i : source has a block on blk_data_i
//   blk_ready_o : injector accepts the block at the next clock edge
interface aurora_see_injector_if #(
  parameter int BLOCK_W = 66
);
  logic [BLOCK_W-1:0] blk_data_i;
  logic               blk_valid_i;
  logic               blk_ready_o;

  modport master (
    output blk_data_i,
    output blk_valid_i,
    input  blk_ready_o
  );

  modport slave (
    input  blk_data_i,
    input  blk_valid_i,
    output blk_ready_o
  );
endinterface

// File: rtl/aurora_see_injector.sv
// Line-impairment model for the Aurora 64b/66b RX test path.
// Accepts blocks over the blk interface and applies LFSR-driven bit flips,
// drops and duplications (up to max_err_i of each per block). It then
// serialises the result MSB-first, one bit per clk_serdes_i cycle.
//   clk_serdes_i  : serial bit clock
//   rst_n_i       : asynchronous active-low reset
//   blk           : block handshake (slave side)
//   inj_en_i      : 0 disables all impairments (pass-through)
//   *_thresh_i    : per-type event probability, out of 2^20
//   max_err_i     : cap on events of each type per block
//   ser_o         : serial data
//   ser_valid_o   : ser_o carries a buffered bit
//   underrun_o    : sticky, serial buffer ran empty once traffic had started
//   blk_cnt_o     : blocks appended to the serial buffer (wraps)
//   flip/drop/add_cnt_o : saturating event counters
module aurora_see_injector #(
  parameter int          BLOCK_W   = 66,
  parameter int          BUF_W     = 3*BLOCK_W,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2468,
  parameter int          CNT_W     = 16
) (
  input  logic                 clk_serdes_i,
  input  logic                 rst_n_i,
  aurora_see_injector_if.slave blk,
  input  logic                 inj_en_i,
  input  logic [19:0]          flip_thresh_i,
  input  logic [19:0]          drop_thresh_i,
  input  logic [19:0]          add_thresh_i,
  input  logic [1:0]           max_err_i,
  output logic                 ser_o,
  output logic                 ser_valid_o,
  output logic                 underrun_o,
  output logic [31:0]          blk_cnt_o,
  output logic [CNT_W-1:0]     flip_cnt_o,
  output logic [CNT_W-1:0]     drop_cnt_o,
  output logic [CNT_W-1:0]     add_cnt_o
);

  // The work register has three spare bits so a block can grow by up to
  // three duplications. BUF_W must be at least 2*BLOCK_W+3 so that a block
  // appended while the buffer still holds up to BLOCK_W bits always fits.
  localparam int          WORK_W    = BLOCK_W + 3;
  localparam int          LEN_W     = $clog2(BUF_W + 1);
  localparam int          CUR_W     = $clog2(WORK_W + 1);
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {IDLE, DRAW, MUTATE, APPEND} state_t;

  state_t             state, state_next;
  logic [31:0]        lfsr;
  logic [BUF_W-1:0]   bit_buf, buf_next;
  logic [LEN_W-1:0]   len, len_base, len_next;
  logic [WORK_W-1:0]  work, work_next;
  logic [CUR_W-1:0]   cur_len, cur_len_next;
  logic [1:0]         rem_flip, rem_drop, rem_add;
  logic [1:0]         rem_flip_next, rem_drop_next, rem_add_next;
  logic [1:0]         draw_flip, draw_drop, draw_add;
  logic [2:0]         events_left;
  logic [CUR_W-1:0]   pos;
  logic [WORK_W-1:0]  below_pos, upto_pos, len_mask;
  logic [WORK_W-1:0]  work_flip, work_drop, work_add;
  logic               flip_hit, drop_hit, add_hit, do_append;
  logic               ready_q, started;

  // Galois step, right-shifting form of x^32+x^22+x^2+x+1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

  // Smaller r means more events: below thresh/16 gives two, below
  // thresh/256 gives three, then the per-block cap applies.
  function automatic logic [1:0] draw_count(input logic [19:0] r,
                                            input logic [19:0] thresh);
    logic [1:0] n;
    n = 2'd0;
    if (inj_en_i && (r < thresh)) begin
      n = 2'd1;
      if (r < (thresh >> 4)) n = 2'd2;
      if (r < (thresh >> 8)) n = 2'd3;
    end
    if (n > max_err_i) n = max_err_i;
    return n;
  endfunction

  assign draw_flip = draw_count(lfsr[19:0], flip_thresh_i);
  assign draw_drop = draw_count(lfsr[19:0], drop_thresh_i);
  assign draw_add  = draw_count(lfsr[19:0], add_thresh_i);

  assign events_left = {1'b0, rem_flip} + {1'b0, rem_drop} + {1'b0, rem_add};

  // Scaling the low LFSR half by the working length keeps the event
  // position inside 0..cur_len-1 without a divider.
  assign pos = CUR_W'((32'(lfsr[15:0]) * 32'(cur_len)) >> 16);

  // Candidate work-register edits for the current event position.
  always_comb begin
    below_pos = ~({WORK_W{1'b1}} << pos);
    upto_pos  = ~({WORK_W{1'b1}} << (pos + CUR_W'(1)));
    len_mask  = ~({WORK_W{1'b1}} << cur_len);
    work_flip = work ^ (WORK_W'(1) << pos);
    work_drop = (work & below_pos) | ((work >> 1) & ~below_pos);
    work_add  = (work & upto_pos) | ((work << 1) & ~upto_pos);
  end

  // FSM state register.
  always_ff @(posedge clk_serdes_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_next;
  end

  // Next state plus work-register and event bookkeeping. MUTATE applies one
  // event per cycle in flip, drop, add order.
  always_comb begin
    state_next    = state;
    work_next     = work;
    cur_len_next  = cur_len;
    rem_flip_next = rem_flip;
    rem_drop_next = rem_drop;
    rem_add_next  = rem_add;
    flip_hit      = 1'b0;
    drop_hit      = 1'b0;
    add_hit       = 1'b0;
    do_append     = 1'b0;
    case (state)
      IDLE: begin
        if (blk.blk_valid_i && ready_q) begin
          work_next    = WORK_W'(blk.blk_data_i);
          cur_len_next = CUR_W'(BLOCK_W);
          state_next   = DRAW;
        end
      end
      DRAW: begin
        rem_flip_next = draw_flip;
        rem_drop_next = draw_drop;
        rem_add_next  = draw_add;
        state_next    = ((draw_flip | draw_drop | draw_add) == 2'd0) ? APPEND : MUTATE;
      end
      MUTATE: begin
        if (rem_flip != 2'd0) begin
          work_next     = work_flip;
          rem_flip_next = rem_flip - 2'd1;
          flip_hit      = 1'b1;
        end else if (rem_drop != 2'd0) begin
          work_next     = work_drop;
          cur_len_next  = cur_len - CUR_W'(1);
          rem_drop_next = rem_drop - 2'd1;
          drop_hit      = 1'b1;
        end else if (rem_add != 2'd0) begin
          work_next     = work_add;
          cur_len_next  = cur_len + CUR_W'(1);
          rem_add_next  = rem_add - 2'd1;
          add_hit       = 1'b1;
        end
        if (events_left <= 3'd1) state_next = APPEND;
      end
      APPEND: begin
        do_append  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The buffer never shifts on output; len just walks down. On append the
  // remaining bits move up by cur_len and the new block fills the bottom.
  always_comb begin
    len_base = (len != '0) ? (len - LEN_W'(1)) : '0;
    len_next = do_append ? (len_base + LEN_W'(cur_len)) : len_base;
    buf_next = do_append ? ((bit_buf << cur_len) | BUF_W'(work & len_mask)) : bit_buf;
  end

  assign ser_valid_o     = (len != '0);
  assign ser_o           = (len != '0) ? bit_buf[len - LEN_W'(1)] : 1'b0;
  assign blk.blk_ready_o = ready_q;

  // Datapath registers and counters. Ready is registered from the next
  // state and length so it reads 0 during reset yet still tracks
  // (IDLE and len<=BLOCK_W) cycle for cycle.
  always_ff @(posedge clk_serdes_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lfsr       <= LFSR_SEED;
      bit_buf    <= '0;
      len        <= '0;
      work       <= '0;
      cur_len    <= '0;
      rem_flip   <= '0;
      rem_drop   <= '0;
      rem_add    <= '0;
      ready_q    <= 1'b0;
      started    <= 1'b0;
      underrun_o <= 1'b0;
      blk_cnt_o  <= '0;
      flip_cnt_o <= '0;
      drop_cnt_o <= '0;
      add_cnt_o  <= '0;
    end else begin
      if (state != IDLE) lfsr <= lfsr_step(lfsr);
      bit_buf    <= buf_next;
      len        <= len_next;
      work       <= work_next;
      cur_len    <= cur_len_next;
      rem_flip   <= rem_flip_next;
      rem_drop   <= rem_drop_next;
      rem_add    <= rem_add_next;
      ready_q    <= (state_next == IDLE) && (len_next <= LEN_W'(BLOCK_W));
      started    <= started | do_append;
      underrun_o <= underrun_o | (started && (len == '0));
      if (do_append) blk_cnt_o <= blk_cnt_o + 32'd1;
      if (flip_hit && (flip_cnt_o != '1)) flip_cnt_o <= flip_cnt_o + CNT_W'(1);
      if (drop_hit && (drop_cnt_o != '1)) drop_cnt_o <= drop_cnt_o + CNT_W'(1);
      if (add_hit  && (add_cnt_o  != '1)) add_cnt_o  <= add_cnt_o  + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_aurora_see_injector.sv
// Testbench for aurora_see_injector.
// Drives random and patterned blocks into the main instance and checks the
// serial stream and counters against a bit-queue reference model. A second
// instance with 4-bit counters runs flip-always traffic to show saturation.
`timescale 1ns/1ps
module tb_aurora_see_injector;
  localparam int          BLOCK_W = 66;
  localparam logic [31:0] SEED    = 32'hACE1_2468;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN;
  logic        injEn;
  logic [19:0] flipTh, dropTh, addTh;
  logic [1:0]  maxErr;
  logic        serO, serValid, underrun;
  logic [31:0] blkCnt;
  logic [15:0] flipCnt, dropCnt, addCnt;

  aurora_see_injector_if #(.BLOCK_W(BLOCK_W)) blkIf ();

  aurora_see_injector #(.BLOCK_W(BLOCK_W)) dut (
    .clk_serdes_i  (clk),
    .rst_n_i       (rstN),
    .blk           (blkIf),
    .inj_en_i      (injEn),
    .flip_thresh_i (flipTh),
    .drop_thresh_i (dropTh),
    .add_thresh_i  (addTh),
    .max_err_i     (maxErr),
    .ser_o         (serO),
    .ser_valid_o   (serValid),
    .underrun_o    (underrun),
    .blk_cnt_o     (blkCnt),
    .flip_cnt_o    (flipCnt),
    .drop_cnt_o    (dropCnt),
    .add_cnt_o     (addCnt)
  );

  logic        rstN2;
  logic        satSer, satValid, satUnder;
  logic [31:0] satBlkCnt;
  logic [3:0]  satFlip, satDrop, satAdd;

  aurora_see_injector_if #(.BLOCK_W(BLOCK_W)) satIf ();

  aurora_see_injector #(.BLOCK_W(BLOCK_W), .CNT_W(4)) dutSat (
    .clk_serdes_i  (clk),
    .rst_n_i       (rstN2),
    .blk           (satIf),
    .inj_en_i      (1'b1),
    .flip_thresh_i (20'hFFFFF),
    .drop_thresh_i (20'h00000),
    .add_thresh_i  (20'h00000),
    .max_err_i     (2'd1),
    .ser_o         (satSer),
    .ser_valid_o   (satValid),
    .underrun_o    (satUnder),
    .blk_cnt_o     (satBlkCnt),
    .flip_cnt_o    (satFlip),
    .drop_cnt_o    (satDrop),
    .add_cnt_o     (satAdd)
  );

  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  bit          expQ[$];
  bit          origQ[$];
  bit          capQ[$];
  bit          capA[$];
  bit          capB[$];
  logic [31:0] mLfsr = SEED;
  int          expFlip = 0, expDrop = 0, expAdd = 0, expBlk = 0;
  int          validCount = 0, firstValid = -1, lastValid = -1, diffCount = 0;
  bit          trackDiff = 0;
  bit          capEn = 0;

  function automatic logic [31:0] lfsrNext(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
  endfunction

  function automatic int drawN(input logic [19:0] r, input logic [19:0] th);
    int n;
    if (!injEn || r >= th)   n = 0;
    else if (r < (th >> 8))  n = 3;
    else if (r < (th >> 4))  n = 2;
    else                     n = 1;
    if (n > int'(maxErr)) n = int'(maxErr);
    return n;
  endfunction

  function automatic int posOf(input int curLen);
    longint p;
    p = (longint'(mLfsr[15:0]) * curLen) >> 16;
    return int'(p);
  endfunction

  // Reference block: bit i of the queue is bit i of the working block.
  function automatic void modelBlock(input logic [BLOCK_W-1:0] d);
    bit q[$];
    int nf, nd, na, p;
    for (int i = 0; i < BLOCK_W; i++) q.push_back(d[i]);
    nf = drawN(mLfsr[19:0], flipTh);
    nd = drawN(mLfsr[19:0], dropTh);
    na = drawN(mLfsr[19:0], addTh);
    mLfsr = lfsrNext(mLfsr);
    for (int k = 0; k < nf; k++) begin
      p = posOf(q.size()); q[p] = !q[p]; mLfsr = lfsrNext(mLfsr);
    end
    for (int k = 0; k < nd; k++) begin
      p = posOf(q.size()); q.delete(p); mLfsr = lfsrNext(mLfsr);
    end
    for (int k = 0; k < na; k++) begin
      p = posOf(q.size()); q.insert(p, q[p]); mLfsr = lfsrNext(mLfsr);
    end
    mLfsr = lfsrNext(mLfsr);
    for (int i = q.size() - 1; i >= 0; i--) expQ.push_back(q[i]);
    if (trackDiff) for (int i = BLOCK_W - 1; i >= 0; i--) origQ.push_back(d[i]);
    expFlip += nf;
    expDrop += nd;
    expAdd  += na;
    expBlk++;
  endfunction

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  // Monitor: model the accepted block and compare every serial bit.
  always @(negedge clk) begin
    bit e, o;
    cycle++;
    if (!rstN) begin
      expQ.delete();
      origQ.delete();
      mLfsr   = SEED;
      expFlip = 0; expDrop = 0; expAdd = 0; expBlk = 0;
    end else begin
      if (serValid) begin
        validCount++;
        if (firstValid < 0) firstValid = cycle;
        lastValid = cycle;
        if (capEn) capQ.push_back(serO);
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL serBit: got unexpected bit %0b, required no bit", serO);
        end else begin
          e = expQ.pop_front();
          if (serO !== e) begin
            errors++;
            $display("[TB] FAIL serBit: got %0b required %0b at cycle %0d", serO, e, cycle);
          end
          if (trackDiff && origQ.size() > 0) begin
            o = origQ.pop_front();
            if (o != serO) diffCount++;
          end
        end
      end
      if (blkIf.blk_valid_i && blkIf.blk_ready_o) modelBlock(blkIf.blk_data_i);
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d required %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [BLOCK_W-1:0] d);
    bit acc;
    int guard;
    acc   = 0;
    guard = 0;
    blkIf.blk_data_i  = d;
    blkIf.blk_valid_i = 1'b1;
    while (!acc && guard < 500) begin
      @(negedge clk);
      acc = blkIf.blk_ready_o;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) checkOutput("acceptTimeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    blkIf.blk_valid_i = 1'b0;
    while (expQ.size() != 0 && guard < 3000) begin
      @(posedge clk);
      guard++;
    end
    checkOutput("drain", 64'(expQ.size()), 64'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rstN = 1'b0;
    blkIf.blk_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstN = 1'b1;
  endtask

  task automatic clearStats();
    validCount = 0;
    firstValid = -1;
    lastValid  = -1;
    diffCount  = 0;
  endtask

  task automatic setImpair(input logic en, input logic [19:0] f, input logic [19:0] dr,
                           input logic [19:0] a, input logic [1:0] m);
    injEn  = en;
    flipTh = f;
    dropTh = dr;
    addTh  = a;
    maxErr = m;
  endtask

  function automatic logic [BLOCK_W-1:0] randBlock();
    return {2'($urandom), $urandom, $urandom};
  endfunction

  task automatic runBlocks(input int n);
    for (int b = 0; b < n; b++) applyStimulus(randBlock());
    drain();
  endtask

  logic [BLOCK_W-1:0] seqA[10];

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN  = 1'b0;
    rstN2 = 1'b0;
    blkIf.blk_valid_i = 1'b0;
    blkIf.blk_data_i  = '0;
    satIf.blk_valid_i = 1'b1;
    satIf.blk_data_i  = 66'h2_0123_4567_89AB_CDEF;
    setImpair(1'b1, 20'h0, 20'h0, 20'h0, 2'd3);
    repeat (2) @(negedge clk);
    checkOutput("rstReady",    64'(blkIf.blk_ready_o), 64'd0);
    checkOutput("rstSerValid", 64'(serValid), 64'd0);
    checkOutput("rstSer",      64'(serO), 64'd0);
    checkOutput("rstBlkCnt",   64'(blkCnt), 64'd0);
    checkOutput("rstUnderrun", 64'(underrun), 64'd0);
    @(posedge clk);
    #1;
    rstN  = 1'b1;
    rstN2 = 1'b1;

    // Pass-through with impairment disabled, 100 counting blocks.
    doReset();
    setImpair(1'b0, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 2'd3);
    clearStats();
    for (int c = 0; c < 100; c++) applyStimulus({2'b01, 32'(c), 32'(c)});
    checkOutput("passUnderrun", 64'(underrun), 64'd0);
    drain();
    checkOutput("passBits",    64'(validCount), 64'd6600);
    checkOutput("passGapFree", 64'(lastValid - firstValid + 1), 64'd6600);
    checkOutput("passBlkCnt",  64'(blkCnt), 64'd100);
    checkOutput("passFlip",    64'(flipCnt), 64'd0);
    checkOutput("passDrop",    64'(dropCnt), 64'd0);
    checkOutput("passAdd",     64'(addCnt), 64'd0);

    // One flip per block.
    doReset();
    setImpair(1'b1, 20'hFFFFF, 20'h0, 20'h0, 2'd1);
    clearStats();
    trackDiff = 1;
    runBlocks(50);
    trackDiff = 0;
    checkOutput("flipCnt",  64'(flipCnt), 64'd50);
    checkOutput("flipDiff", 64'(diffCount), 64'd50);
    checkOutput("flipBits", 64'(validCount), 64'd3300);

    // One drop per block.
    doReset();
    setImpair(1'b1, 20'h0, 20'hFFFFF, 20'h0, 2'd1);
    clearStats();
    runBlocks(40);
    checkOutput("dropCnt",  64'(dropCnt), 64'd40);
    checkOutput("dropBits", 64'(validCount), 64'd2600);

    // One duplication per block, then the same with the cap at zero.
    doReset();
    setImpair(1'b1, 20'h0, 20'h0, 20'hFFFFF, 2'd1);
    clearStats();
    runBlocks(40);
    checkOutput("addCnt",  64'(addCnt), 64'd40);
    checkOutput("addBits", 64'(validCount), 64'd2680);
    doReset();
    setImpair(1'b1, 20'h0, 20'h0, 20'hFFFFF, 2'd0);
    clearStats();
    runBlocks(40);
    checkOutput("addCnt0",  64'(addCnt), 64'd0);
    checkOutput("addBits0", 64'(validCount), 64'd2640);

    // Starvation: three blocks, then a long idle gap.
    doReset();
    setImpair(1'b1, 20'h0, 20'h0, 20'h0, 2'd3);
    clearStats();
    for (int b = 0; b < 3; b++) applyStimulus(randBlock());
    blkIf.blk_valid_i = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    checkOutput("starveBits",   64'(validCount), 64'd198);
    checkOutput("starveRun",    64'(lastValid - firstValid + 1), 64'd198);
    checkOutput("starveValid",  64'(serValid), 64'd0);
    checkOutput("starveUnder",  64'(underrun), 64'd1);
    for (int b = 0; b < 3; b++) applyStimulus(randBlock());
    checkOutput("resumeUnder",  64'(underrun), 64'd1);
    drain();
    checkOutput("resumeUnder2", 64'(underrun), 64'd1);
    checkOutput("resumeBlkCnt", 64'(blkCnt), 64'd6);

    // Reset in the middle of MUTATE.
    doReset();
    setImpair(1'b1, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 2'd3);
    applyStimulus(randBlock());
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b0;
    blkIf.blk_valid_i = 1'b0;
    @(negedge clk);
    checkOutput("midRstSerValid", 64'(serValid), 64'd0);
    checkOutput("midRstSer",      64'(serO), 64'd0);
    checkOutput("midRstReady",    64'(blkIf.blk_ready_o), 64'd0);
    checkOutput("midRstFlip",     64'(flipCnt), 64'd0);
    checkOutput("midRstBlkCnt",   64'(blkCnt), 64'd0);
    @(posedge clk);
    #1;
    rstN = 1'b1;

    // The impaired stream must repeat exactly from reset.
    for (int i = 0; i < 10; i++) seqA[i] = randBlock();
    for (int run = 0; run < 2; run++) begin
      doReset();
      capQ.delete();
      capEn = 1;
      for (int i = 0; i < 10; i++) applyStimulus(seqA[i]);
      drain();
      capEn = 0;
      if (run == 0) capA = capQ;
      else          capB = capQ;
    end
    begin
      int mism;
      mism = 0;
      checkOutput("rerunLen", 64'(capB.size()), 64'(capA.size()));
      for (int i = 0; i < capA.size() && i < capB.size(); i++)
        if (capA[i] != capB[i]) mism++;
      checkOutput("rerunBits", 64'(mism), 64'd0);
    end

    // Random impairment settings with random idle gaps.
    for (int s = 0; s < 3; s++) begin
      setImpair(1'($urandom_range(0, 3) != 0), 20'($urandom), 20'($urandom),
                20'($urandom), 2'($urandom_range(0, 3)));
      doReset();
      for (int b = 0; b < 40; b++) begin
        applyStimulus(randBlock());
        if ($urandom_range(0, 3) == 0) begin
          blkIf.blk_valid_i = 1'b0;
          repeat ($urandom_range(1, 80)) @(posedge clk);
          #1;
        end
      end
      drain();
      checkOutput("randFlip",   64'(flipCnt), 64'(sat16(expFlip)));
      checkOutput("randDrop",   64'(dropCnt), 64'(sat16(expDrop)));
      checkOutput("randAdd",    64'(addCnt),  64'(sat16(expAdd)));
      checkOutput("randBlkCnt", 64'(blkCnt),  64'(expBlk));
    end

    // The 4-bit-counter instance has been flipping every block all along.
    checkOutput("satBlocks", 64'(satBlkCnt >= 32'd20), 64'd1);
    checkOutput("satFlip",   64'(satFlip), 64'd15);
    checkOutput("satDrop",   64'(satDrop), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
